// File: rtl/con_seq.sv
// ---------------------------------------------------------------------------
// con_seq : registered bit-pattern sequencer.
//
// Holds a WIDTH-bit pattern that advances one position on each accepted step,
// either rotating left, rotating right, or (optionally) running a Galois LFSR.
// A step counter tracks accepted steps since the last reset, load or wrap.
// A one-cycle wrap pulse marks a step that returned the pattern to INIT.
//
// Optional feature: LFSR mode (mode 11) is built in only when the macro
// CON_SEQ_LFSR_EN is defined. In the default build, mode 11 behaves as HOLD.
//
// Ports
//   clk     in          rising-edge clock for all state
//   rst_n   in          synchronous active-low reset
//   mode    in  [1:0]   00 HOLD, 01 ROTL, 10 ROTR, 11 LFSR
//   step    in          advance the pattern this cycle
//   ld      in          load ld_val this cycle (wins over step)
//   ld_val  in  [W-1:0] value to load
//   con     out [W-1:0] current pattern (registered)
//   wrap    out         one-cycle pulse: last step landed on INIT
//   cnt     out [CW-1:0] accepted steps since reset/load/wrap, saturating
// ---------------------------------------------------------------------------
module con_seq #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(1),
  parameter int              CW    = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] con,
  output logic             wrap,
  output logic [CW-1:0]    cnt
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ROTL = 2'b01;
  localparam logic [1:0] MODE_ROTR = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

`ifdef CON_SEQ_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  logic [WIDTH-1:0] con_q, con_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] pat_nxt;
  logic             hold;
  logic             accept;

  // An all-zero LFSR state would never leave zero, so it restarts from INIT.
  // Without LFSR_EN this path is unreachable and drops out in synthesis.
  always_comb begin
    lfsr_nxt = INIT;
    if (con_q != '0) begin
      lfsr_nxt = (con_q >> 1) ^ (con_q[0] ? TAPS : '0);
    end
  end

  always_comb begin
    pat_nxt = con_q;
    case (mode)
      MODE_ROTL: pat_nxt = {con_q[WIDTH-2:0], con_q[WIDTH-1]};
      MODE_ROTR: pat_nxt = {con_q[0], con_q[WIDTH-1:1]};
      MODE_LFSR: pat_nxt = lfsr_nxt;
      default:   pat_nxt = con_q;
    endcase
  end

  assign hold   = (mode == MODE_HOLD) || ((mode == MODE_LFSR) && !LFSR_EN);
  assign accept = step && !ld && !hold;

  always_comb begin
    con_d  = con_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (ld) begin
      con_d = ld_val;
      cnt_d = '0;
    end else if (accept) begin
      con_d = pat_nxt;
      if (pat_nxt == INIT) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      con_q  <= INIT;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      con_q  <= con_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign con  = con_q;
  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_con_seq.sv
// ---------------------------------------------------------------------------
// tb_con_seq : directed self-checking bench for con_seq (WIDTH=8, INIT=01,
// CW=8, TAPS=B8). Inputs change 1 time unit after a rising edge; outputs are
// checked 1 time unit after the edge that registers them.
// ---------------------------------------------------------------------------
module tb_con_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       step;
  logic       ld;
  logic [7:0] ld_val;
  logic [7:0] con;
  logic       wrap;
  logic [7:0] cnt;

  int checks;
  int failures;

  con_seq #(
    .WIDTH(8),
    .INIT (8'h01),
    .CW   (8),
    .TAPS (8'hB8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .step  (step),
    .ld    (ld),
    .ld_val(ld_val),
    .con   (con),
    .wrap  (wrap),
    .cnt   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step = 1'b0; ld = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b01; step = 1'b1; ld = 1'b1; ld_val = 8'hAA;
    cyc();
    checks++; if (con !== 8'h01) begin failures++; $display("FAIL reset_con got=%h exp=01", con); end
    checks++; if (cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", cnt); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    rst_n = 1'b1; step = 1'b0; ld = 1'b0;
  endtask

  task automatic test_rotl();
    logic [7:0] exp_con [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] exp_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0};
    do_reset();
    mode = 2'b01; step = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (con !== exp_con[i]) begin failures++; $display("FAIL rotl_con[%0d] got=%h exp=%h", i, con, exp_con[i]); end
      checks++; if (cnt !== exp_cnt[i]) begin failures++; $display("FAIL rotl_cnt[%0d] got=%h exp=%h", i, cnt, exp_cnt[i]); end
      checks++; if (wrap !== (i == 7)) begin failures++; $display("FAIL rotl_wrap[%0d] got=%b exp=%b", i, wrap, (i == 7)); end
    end
    step = 1'b0;
    cyc();
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rotl_wrap_drop got=%b exp=0", wrap); end
    checks++; if (con !== 8'h01) begin failures++; $display("FAIL rotl_idle_con got=%h exp=01", con); end
  endtask

  task automatic test_rotr();
    do_reset();
    mode = 2'b10; step = 1'b1;
    cyc();
    step = 1'b0;
    checks++; if (con !== 8'h80) begin failures++; $display("FAIL rotr_con got=%h exp=80", con); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL rotr_cnt got=%h exp=01", cnt); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rotr_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_load_priority();
    mode = 2'b01; step = 1'b1; ld = 1'b1; ld_val = 8'h5A;
    cyc();
    ld = 1'b0;
    checks++; if (con !== 8'h5A) begin failures++; $display("FAIL ld_con got=%h exp=5A", con); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL ld_cnt got=%h exp=00", cnt); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL ld_wrap got=%b exp=0", wrap); end
    cyc();
    step = 1'b0;
    checks++; if (con !== 8'hB4) begin failures++; $display("FAIL ld_step_con got=%h exp=B4", con); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL ld_step_cnt got=%h exp=01", cnt); end
  endtask

  // Continues from con=B4, cnt=1.
  task automatic test_hold_and_mode_change();
    mode = 2'b00; step = 1'b1;
    repeat (3) cyc();
    checks++; if (con !== 8'hB4) begin failures++; $display("FAIL hold_con got=%h exp=B4", con); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL hold_cnt got=%h exp=01", cnt); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL hold_wrap got=%b exp=0", wrap); end
    mode = 2'b10;
    cyc();
    step = 1'b0;
    checks++; if (con !== 8'h5A) begin failures++; $display("FAIL modechg_con got=%h exp=5A", con); end
    checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL modechg_cnt got=%h exp=02", cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 2'b01; step = 1'b1;
    repeat (3) cyc();
    checks++; if (con !== 8'h08) begin failures++; $display("FAIL mid_pre_con got=%h exp=08", con); end
    checks++; if (cnt !== 8'd3) begin failures++; $display("FAIL mid_pre_cnt got=%h exp=03", cnt); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; step = 1'b0;
    checks++; if (con !== 8'h01) begin failures++; $display("FAIL mid_rst_con got=%h exp=01", con); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_cnt got=%h exp=00", cnt); end
    step = 1'b1;
    cyc();
    step = 1'b0;
    checks++; if (con !== 8'h02) begin failures++; $display("FAIL mid_step_con got=%h exp=02", con); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL mid_step_cnt got=%h exp=01", cnt); end
  endtask

  task automatic test_wrap_from_load();
    ld = 1'b1; ld_val = 8'h02; mode = 2'b10;
    cyc();
    ld = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0;
    checks++; if (con !== 8'h01) begin failures++; $display("FAIL rotr_wrap_con got=%h exp=01", con); end
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL rotr_wrap_pulse got=%b exp=1", wrap); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL rotr_wrap_cnt got=%h exp=00", cnt); end
    cyc();
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rotr_wrap_drop got=%b exp=0", wrap); end
  endtask

  task automatic test_saturate_and_uniform();
    int wraps;
    wraps = 0;
    ld = 1'b1; ld_val = 8'h00; mode = 2'b01;
    cyc();
    ld = 1'b0; step = 1'b1;
    for (int i = 0; i < 260; i++) begin
      cyc();
      if (wrap) wraps++;
    end
    step = 1'b0;
    checks++; if (cnt !== 8'hFF) begin failures++; $display("FAIL sat_cnt got=%h exp=FF", cnt); end
    checks++; if (con !== 8'h00) begin failures++; $display("FAIL zero_rot_con got=%h exp=00", con); end
    checks++; if (wraps !== 0) begin failures++; $display("FAIL zero_rot_wraps got=%0d exp=0", wraps); end
    ld = 1'b1; ld_val = 8'hFF;
    cyc();
    ld = 1'b0; step = 1'b1; mode = 2'b10;
    repeat (2) cyc();
    step = 1'b0;
    checks++; if (con !== 8'hFF) begin failures++; $display("FAIL ones_rot_con got=%h exp=FF", con); end
    checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL ones_rot_cnt got=%h exp=02", cnt); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL ones_rot_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_mode11();
    do_reset();
`ifdef CON_SEQ_LFSR_EN
    mode = 2'b11; step = 1'b1;
    cyc();
    checks++; if (con !== 8'hB8) begin failures++; $display("FAIL lfsr1_con got=%h exp=B8", con); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL lfsr1_cnt got=%h exp=01", cnt); end
    cyc();
    step = 1'b0;
    checks++; if (con !== 8'h5C) begin failures++; $display("FAIL lfsr2_con got=%h exp=5C", con); end
    checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL lfsr2_cnt got=%h exp=02", cnt); end
    ld = 1'b1; ld_val = 8'h00;
    cyc();
    ld = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0;
    checks++; if (con !== 8'h01) begin failures++; $display("FAIL lfsr_lock_con got=%h exp=01", con); end
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL lfsr_lock_wrap got=%b exp=1", wrap); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL lfsr_lock_cnt got=%h exp=00", cnt); end
`else
    mode = 2'b11; step = 1'b1;
    repeat (5) cyc();
    step = 1'b0;
    checks++; if (con !== 8'h01) begin failures++; $display("FAIL m11_hold_con got=%h exp=01", con); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL m11_hold_cnt got=%h exp=00", cnt); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL m11_hold_wrap got=%b exp=0", wrap); end
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; mode = 2'b00; step = 1'b0; ld = 1'b0; ld_val = 8'h00;
    #1;
    test_reset();
    test_rotl();
    test_rotr();
    test_load_priority();
    test_hold_and_mode_change();
    test_reset_mid();
    test_wrap_from_load();
    test_saturate_and_uniform();
    test_mode11();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
